vga_line_fetch_ctrl: RTL and testbench
======================================

// Module: vga_line_fetch_ctrl
// PURPOSE
//  Frame-buffer read scheduler in front of the 1024x768 VGA timing generator.
//  Issues fixed-length burst reads from a linear frame buffer, stores them in a local pixel FIFO,
//  and serves one 24-bit pixel per cycle when the timing generator asserts pixel_de.
//  Restarts at base address on every frame-start pulse.
// PARAMETERS
//  H_ACTIVE     1024     active pixels per line
//  V_ACTIVE     768      active lines per frame
//  BURST_LEN    64       pixels (32-bit words) per read burst
//  FIFO_AW      8        FIFO address width; depth = 2**FIFO_AW (must be >= 2*BURST_LEN)
//  ADDR_W       32       byte-address width
//  BASE_ADDR    32'h0    frame-buffer byte base; 4 bytes per pixel
// PORTS
//  sclk          in   1       single clock (timing generator runs on the same clock)
//  rst_n         in   1       asynchronous active-low reset
//  frame_start   in   1       one-cycle pulse, first pixel of frame (timing generator's start flag)
//  pix_en        in   1       pixel_de from timing generator; pops one pixel
//  pix_data      out  24      FIFO head, first-word fall-through; 0 when empty
//  rd_req        out  1       burst request; held until rd_ack
//  rd_ack        in   1       request accepted (same cycle as rd_req counts)
//  rd_addr       out  ADDR_W  burst byte address, stable while rd_req=1
//  rd_len        out  16      constant BURST_LEN
//  rd_vld        in   1       read-data beat valid
//  rd_data       in   32      read data; [23:0] = RGB
//  busy          out  1       1 while a frame fetch is in progress
//  uflow         out  1       sticky: pix_en seen with FIFO empty; cleared by frame_start
// BEHAVIOUR
//  Reset: rd_req=0, rd_addr=BASE_ADDR, busy=0, uflow=0, FIFO empty, pix_data=0, state IDLE.
//  FSM: IDLE -> ARM on frame_start.
//   ARM: flush FIFO, rd_addr=BASE_ADDR, bursts_left=H_ACTIVE*V_ACTIVE/BURST_LEN, busy=1; -> CHECK.
//   CHECK: bursts_left==0 -> IDLE (busy=0); else if fill <= DEPTH-BURST_LEN -> REQ; else stay.
//   REQ: rd_req=1; on rd_ack -> DATA, bursts_left--, rd_addr += 4*BURST_LEN (wraps mod 2**ADDR_W).
//   DATA: push each rd_vld beat; after BURST_LEN beats -> CHECK. rd_vld outside DATA/DRAIN is ignored.
//   DRAIN: accept and discard remaining beats of outstanding burst; after last beat -> ARM.
//  Handshake: rd_req never deasserts before rd_ack; at most one burst outstanding;
//   request issue requires space for full burst, so FIFO never overflows.
//  frame_start while in REQ: finish handshake, then DRAIN the granted burst, then ARM.
//  frame_start while in DATA: -> DRAIN (beats of current burst already counted continue).
//  frame_start while in CHECK/IDLE: -> ARM next cycle.
//  Same-cycle push+pop: both take effect, fill unchanged. Pop when empty: no pointer move,
//   pix_data=0, uflow<=1. frame_start and underflow in same cycle: clear wins.
//  Latency: first request 2 cycles after frame_start (ARM, CHECK); pix_data is valid the cycle
//   after the first beat is pushed.
//  H_ACTIVE*V_ACTIVE % BURST_LEN != 0 is an elaboration error.
//  Reset mid-burst: everything returns to reset values; no drain of pending bus beats.
// CONFIGURATION
//  FETCH_UFLOW_CNT_EN defined: adds output uflow_cnt[15:0], saturating count of underflow pops,
//   reset 0, cleared by frame_start (clear wins over increment).
//  Not defined: port and counter absent; uflow flag unchanged.
// STRUCTURE
//  vga_fetch_pkg: FSM state encoding (IDLE, ARM, CHECK, REQ, DATA, DRAIN), bytes-per-pixel=4,
//   burst-byte-stride constant, rd_len width.
//  Sub-module fetch_sync_fifo: single-clock FWFT FIFO, width 24, depth 2**FIFO_AW,
//   ports push/pop/flush/fill/empty.
// TESTING (sim params H_ACTIVE=16 V_ACTIVE=4 BURST_LEN=8 FIFO_AW=5 BASE_ADDR=32'h1000)
//  1 frame_start, rd_ack immediate, rd_data=pixel index -> 8 bursts, addrs 0x1000..0x10E0
//    step 0x20, busy falls after 8th burst.
//  2 pix_en held 64 cycles after fill -> pix_data 0..63 in order, uflow stays 0.
//  3 pix_en never asserted -> at most 4 bursts granted (fill 32), rd_req low until pops free 8.
//  4 rd_ack delayed 5 cycles -> rd_req/rd_addr stable all 5 cycles, one burst only.
//  5 frame_start in DATA after 3 beats -> 5 beats discarded, next rd_addr=0x1000,
//    FIFO empty on restart.
//  6 pix_en on empty FIFO -> pix_data=0, uflow=1; with FETCH_UFLOW_CNT_EN 3 pops -> uflow_cnt=3,
//    frame_start clears both.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared FSM encoding and bus constants for the VGA frame-buffer fetch path.
package vga_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CHECK,
        ST_REQ,
        ST_DATA,
        ST_DRAIN
    } fetch_state_t;

    localparam int BYTES_PER_PIX = 4;
    localparam int RD_LEN_W      = 16;

    function automatic int burst_stride(input int burst_len);
        return BYTES_PER_PIX * burst_len;
    endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// fetch_sync_fifo: single-clock first-word-fall-through FIFO; dout reads 0 while empty.
module fetch_sync_fifo #(
    parameter int W  = 24,
    parameter int AW = 8
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   fill,
    output logic          empty
);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign fill    = wr_ptr - rd_ptr;
    assign empty   = fill == '0;
    assign do_push = push && !fill[AW];
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
            rd_ptr <= do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
        end
    end

    always_ff @(posedge sclk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// vga_line_fetch_ctrl: burst-read scheduler feeding a pixel FIFO for the VGA timing generator.
// Define FETCH_UFLOW_CNT_EN to add the saturating uflow_cnt underflow counter output.
module vga_line_fetch_ctrl
    import vga_fetch_pkg::*;
#(
    parameter int                H_ACTIVE  = 1024,
    parameter int                V_ACTIVE  = 768,
    parameter int                BURST_LEN = 64,
    parameter int                FIFO_AW   = 8,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                pix_en,
    output logic [23:0]         pix_data,
    output logic                rd_req,
    input  logic                rd_ack,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [RD_LEN_W-1:0] rd_len,
    input  logic                rd_vld,
    input  logic [31:0]         rd_data,
    output logic                busy,
    output logic                uflow
`ifdef FETCH_UFLOW_CNT_EN
    ,
    output logic [15:0]         uflow_cnt
`endif
);

    localparam int                DEPTH        = 2**FIFO_AW;
    localparam int                TOTAL_BURSTS = H_ACTIVE * V_ACTIVE / BURST_LEN;
    localparam int                BL_W         = $clog2(TOTAL_BURSTS + 1);
    localparam int                BC_W         = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] STRIDE       = ADDR_W'(burst_stride(BURST_LEN));
    localparam logic [FIFO_AW:0]  ROOM_MAX     = (FIFO_AW+1)'(DEPTH - BURST_LEN);

    if ((H_ACTIVE * V_ACTIVE) % BURST_LEN != 0) begin : g_bad_geom
        $error("frame pixel count must be a multiple of BURST_LEN");
    end
    if (DEPTH < 2 * BURST_LEN) begin : g_bad_depth
        $error("FIFO depth must be at least two bursts");
    end

    fetch_state_t     state, state_nxt;
    logic [BL_W-1:0]  bursts_left;
    logic [BC_W-1:0]  beat_cnt;
    logic [FIFO_AW:0] fill;
    logic             empty, fs_pend, fifo_push, fifo_flush, last_beat, granted, underflow;
    logic             unused_rgb_pad;

    assign rd_req         = state == ST_REQ;
    assign rd_len         = RD_LEN_W'(BURST_LEN);
    assign granted        = rd_req && rd_ack;
    assign underflow      = pix_en && empty;
    assign last_beat      = rd_vld && beat_cnt == BC_W'(BURST_LEN - 1);
    assign unused_rgb_pad = ^rd_data[31:24];

    fetch_sync_fifo #(.W(24), .AW(FIFO_AW)) u_fifo (
        .sclk  (sclk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pix_en),
        .flush (fifo_flush),
        .din   (rd_data[23:0]),
        .dout  (pix_data),
        .fill  (fill),
        .empty (empty)
    );

    always_comb begin
        state_nxt  = state;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = frame_start ? ST_ARM : ST_IDLE;
            ST_ARM: begin
                fifo_flush = 1'b1;
                state_nxt  = ST_CHECK;
            end
            ST_CHECK: state_nxt = frame_start ? ST_ARM :
                                  bursts_left == '0 ? ST_IDLE :
                                  fill <= ROOM_MAX ? ST_REQ : ST_CHECK;
            // a restart during the handshake still owes the bus the granted burst
            ST_REQ:   state_nxt = !rd_ack ? ST_REQ : (frame_start || fs_pend) ? ST_DRAIN : ST_DATA;
            ST_DATA: begin
                fifo_push = rd_vld;
                state_nxt = last_beat ? (frame_start ? ST_ARM : ST_CHECK) :
                            frame_start ? ST_DRAIN : ST_DATA;
            end
            ST_DRAIN: state_nxt = last_beat ? ST_ARM : ST_DRAIN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rd_addr     <= BASE_ADDR;
            bursts_left <= '0;
            beat_cnt    <= '0;
            fs_pend     <= 1'b0;
            busy        <= 1'b0;
            uflow       <= 1'b0;
        end else begin
            state    <= state_nxt;
            fs_pend  <= rd_req && !rd_ack && (fs_pend || frame_start);
            beat_cnt <= rd_req ? '0 :
                        ((state == ST_DATA || state == ST_DRAIN) && rd_vld) ? beat_cnt + BC_W'(1) : beat_cnt;
            if (state == ST_ARM) begin
                rd_addr     <= BASE_ADDR;
                bursts_left <= BL_W'(TOTAL_BURSTS);
            end else if (granted) begin
                rd_addr     <= rd_addr + STRIDE;
                bursts_left <= bursts_left - BL_W'(1);
            end
            busy  <= state == ST_ARM ? 1'b1 : (state == ST_CHECK && state_nxt == ST_IDLE) ? 1'b0 : busy;
            uflow <= frame_start ? 1'b0 : underflow ? 1'b1 : uflow;
        end
    end

`ifdef FETCH_UFLOW_CNT_EN
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)
            uflow_cnt <= '0;
        else
            uflow_cnt <= frame_start ? '0 : (underflow && uflow_cnt != '1) ? uflow_cnt + 16'd1 : uflow_cnt;
    end
`endif

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// tb_vga_line_fetch_ctrl: directed bench with a burst-read responder for vga_line_fetch_ctrl.
module tb_vga_line_fetch_ctrl;

    logic        sclk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, pix_en = 1'b0;
    logic        rd_ack, rd_vld, rd_req, busy, uflow;
    logic [31:0] rd_data, rd_addr;
    logic [23:0] pix_data;
    logic [15:0] rd_len;
`ifdef FETCH_UFLOW_CNT_EN
    logic [15:0] uflow_cnt;
`endif

    int          n_checks = 0, n_fail = 0;
    int          max_grants = 0, ack_delay = 0, data_off = 0, beats_sent = 0;
    logic [31:0] grant_q[$];
    logic [31:0] resp_addr;

    typedef struct {
        logic        fs;
        logic        pe;
        logic [23:0] pix;
        logic        uf;
        logic [15:0] cnt;
        logic        bsy;
        logic        req;
    } vec_t;
    vec_t tv [8];

    vga_line_fetch_ctrl #(
        .H_ACTIVE(16), .V_ACTIVE(4), .BURST_LEN(8), .FIFO_AW(5), .ADDR_W(32), .BASE_ADDR(32'h1000)
    ) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .pix_data    (pix_data),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .rd_vld      (rd_vld),
        .rd_data     (rd_data),
        .busy        (busy),
        .uflow       (uflow)
`ifdef FETCH_UFLOW_CNT_EN
        ,
        .uflow_cnt   (uflow_cnt)
`endif
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        max_grants = 0;
        pix_en     = 1'b0;
        tick(20);
        rst_n = 1'b0;
        tick(2);
        grant_q.delete();
        beats_sent = 0;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic wait_grants(input string name, input int n, input int budget);
        int cyc = 0;
        while (grant_q.size() < n && cyc < budget) begin
            @(posedge sclk);
            #2;
            cyc++;
        end
        chk(name, grant_q.size(), n);
    endtask

    // Bus model: grants after ack_delay cycles, then streams 8 beats tagged with the pixel index
    initial begin
        rd_ack  = 1'b0;
        rd_vld  = 1'b0;
        rd_data = '0;
        forever begin
            @(posedge sclk);
            #1;
            if (rst_n && rd_req && grant_q.size() < max_grants) begin
                repeat (ack_delay) begin
                    @(posedge sclk);
                    #1;
                end
                resp_addr = rd_addr;
                grant_q.push_back(resp_addr);
                rd_ack = 1'b1;
                @(posedge sclk);
                #1;
                rd_ack = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    rd_vld  = 1'b1;
                    rd_data = {8'hAA, 24'(data_off + int'((resp_addr - 32'h1000) >> 2) + k)};
                    beats_sent++;
                    @(posedge sclk);
                    #1;
                end
                rd_vld = 1'b0;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        //          fs    pe    pix    uf    cnt    bsy   req
        tv[0] = '{1'b0, 1'b1, 24'h0, 1'b0, 16'd0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 24'h0, 1'b1, 16'd1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 24'h0, 1'b1, 16'd2, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b1, 24'h0, 1'b1, 16'd3, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b0, 24'h0, 1'b0, 16'd0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b0, 24'h0, 1'b0, 16'd0, 1'b1, 1'b0};
        tv[6] = '{1'b0, 1'b1, 24'h0, 1'b0, 16'd0, 1'b1, 1'b1};
        tv[7] = '{1'b0, 1'b0, 24'h0, 1'b1, 16'd1, 1'b1, 1'b1};

        tick(3);
        rst_n = 1'b1;
        tick(2);
        @(negedge sclk);
        chk("reset rd_req", rd_req, 0);
        chk("reset rd_addr", rd_addr, 32'h1000);
        chk("reset busy", busy, 0);
        chk("reset uflow", uflow, 0);
        chk("reset pix_data", pix_data, 0);
        chk("rd_len", rd_len, 8);
        tick();

        // underflow flag/counter and clear-wins, no bus grants
        for (int i = 0; i < 8; i++) begin
            frame_start = tv[i].fs;
            pix_en      = tv[i].pe;
            @(negedge sclk);
            chk($sformatf("uf row%0d pix_data", i), pix_data, tv[i].pix);
            chk($sformatf("uf row%0d uflow", i), uflow, tv[i].uf);
            chk($sformatf("uf row%0d busy", i), busy, tv[i].bsy);
            chk($sformatf("uf row%0d rd_req", i), rd_req, tv[i].req);
`ifdef FETCH_UFLOW_CNT_EN
            chk($sformatf("uf row%0d uflow_cnt", i), uflow_cnt, tv[i].cnt);
`endif
            tick();
        end
        frame_start = 1'b0;
        pix_en      = 1'b0;

        // full frame with immediate ack, then pop all 64 pixels
        do_reset();
        max_grants = 100;
        data_off   = 0;
        pulse_fs();
        tick(60);
        @(negedge sclk);
        chk("frame busy", busy, 1);
        chk("frame fill grants", grant_q.size(), 4);
        tick();
        pix_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge sclk);
            chk($sformatf("pixel %0d", i), pix_data, i);
            tick();
        end
        pix_en = 1'b0;
        tick(10);
        @(negedge sclk);
        chk("frame grants", grant_q.size(), 8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk($sformatf("burst %0d addr", i), grant_q[i], 32'h1000 + 32'h20 * i);
        chk("frame end busy", busy, 0);
        chk("frame end uflow", uflow, 0);
        chk("frame end pix_data", pix_data, 0);
        chk("frame end rd_req", rd_req, 0);

        // no consumer: FIFO fills to 4 bursts and requests wait for a full burst of room
        do_reset();
        max_grants = 100;
        pulse_fs();
        tick(80);
        @(negedge sclk);
        chk("stall grants", grant_q.size(), 4);
        chk("stall rd_req", rd_req, 0);
        tick();
        pix_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge sclk);
            chk($sformatf("stall pop %0d", i), pix_data, i);
            tick();
        end
        pix_en = 1'b0;
        tick(4);
        @(negedge sclk);
        chk("fill 25 rd_req", rd_req, 0);
        chk("fill 25 grants", grant_q.size(), 4);
        tick();
        pix_en = 1'b1;
        @(negedge sclk);
        chk("stall pop 7", pix_data, 7);
        tick();
        pix_en = 1'b0;
        wait_grants("fill 24 grant", 5, 10);

        // delayed ack: request and address held stable
        do_reset();
        ack_delay  = 5;
        max_grants = 1;
        pulse_fs();
        begin
            int cyc = 0;
            @(negedge sclk);
            while (!rd_req && cyc < 10) begin
                @(negedge sclk);
                cyc++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold %0d rd_req", k), rd_req, 1);
            chk($sformatf("hold %0d rd_addr", k), rd_addr, 32'h1000);
            @(negedge sclk);
        end
        tick(30);
        @(negedge sclk);
        chk("delay grants", grant_q.size(), 1);
        chk("delay next rd_req", rd_req, 1);
        chk("delay next rd_addr", rd_addr, 32'h1020);
        ack_delay = 0;
        tick();

        // restart inside a burst: rest of burst drained, FIFO empty, fetch restarts at base
        do_reset();
        data_off   = 24'h50_0000;
        max_grants = 100;
        pulse_fs();
        begin
            int cyc = 0;
            while (beats_sent < 3 && cyc < 40) begin
                @(posedge sclk);
                #2;
                cyc++;
            end
        end
        chk("restart beats before", beats_sent, 3);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_grants("restart grant", 2, 40);
        chk("restart empty pix_data", pix_data, 0);
        chk("restart beats drained", beats_sent, 8);
        if (grant_q.size() > 1)
            chk("restart addr", grant_q[1], 32'h1000);
        tick(12);
        pix_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sclk);
            chk($sformatf("restart pixel %0d", i), pix_data, 32'h50_0000 + i);
            tick();
        end
        pix_en = 1'b0;
        max_grants = 0;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
